reg_mem_transfer: RTL and testbench

//  Sequencer for CHIP-8 Fx55 (store V0..Vx to memory at I) and Fx65 (load V0..Vx from memory at I).

---
 rtl/chip8_pkg.sv | 28 ++
 rtl/reg_mem_transfer.sv | 156 +++++++++++++++
 tb/tb_reg_mem_transfer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg: shared types and constants for the CHIP-8 register/memory
// transfer sequencer (Fx55 / Fx65).
//   state_t     : sequencer FSM states
//   DIR_STORE   : regs -> mem (Fx55)
//   DIR_LOAD    : mem -> regs (Fx65)
//   ADDR_W_DEF  : default RAM address width
//   DATA_W_DEF  : default register / memory data width
//   REG_COUNT   : number of V registers
//   SEL_W       : register select width
package chip8_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int REG_COUNT  = 16;
  localparam int SEL_W      = $clog2(REG_COUNT);

  localparam logic DIR_STORE = 1'b0;
  localparam logic DIR_LOAD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    LOAD_TAIL,
    DONE
  } state_t;

endpackage

// File: rtl/reg_mem_transfer.sv
// reg_mem_transfer: sequencer for CHIP-8 Fx55 (store V0..Vx to RAM at I) and
// Fx65 (load V0..Vx from RAM at I). Moves one register per cycle, then pulses
// done for one cycle.
//
// Ports
//   clk, reset                  clock, async active-high reset
//   start, dir, last_reg,
//   base_addr                   request; sampled only in IDLE
//   busy, done                  status; done is a 1-cycle pulse in the last cycle
//   rf_select_out, rf_out_data  register-file async read port
//   rf_we, rf_select_in,
//   rf_in_data                  register-file write port
//   mem_addr, mem_we,
//   mem_wdata, mem_rdata        synchronous RAM port (read data 1 cycle late)
//   i_upd_en, i_upd_val         I-register update strobe / value
//
// Build option: CHIP8_I_INCREMENT_EN
//   defined   -> in DONE, i_upd_en=1 and i_upd_val=I+x+1 (COSMAC behaviour)
//   undefined -> i_upd_en / i_upd_val tied to 0 (I unchanged)
module reg_mem_transfer
  import chip8_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [SEL_W-1:0]  last_reg,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [SEL_W-1:0]  rf_select_out,
  input  logic [DATA_W-1:0] rf_out_data,
  output logic              rf_we,
  output logic [SEL_W-1:0]  rf_select_in,
  output logic [DATA_W-1:0] rf_in_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              i_upd_en,
  output logic [ADDR_W-1:0] i_upd_val
);

  state_t           state;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] x_q;

  // Data paths stay combinational: the register file read and the RAM read
  // both land in the same cycle the matching strobe is high. Gating keeps
  // them at zero whenever no write is in progress.
  assign mem_wdata  = mem_we ? rf_out_data : '0;
  assign rf_in_data = rf_we  ? mem_rdata   : '0;

`ifndef CHIP8_I_INCREMENT_EN
  assign i_upd_en  = 1'b0;
  assign i_upd_val = '0;
`endif

  // mem_addr itself is the running base+k pointer; it is left at base+x
  // through LOAD_TAIL so that I+x+1 is simply mem_addr+1 on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      x_q           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rf_select_out <= '0;
      rf_we         <= 1'b0;
      rf_select_in  <= '0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
`ifdef CHIP8_I_INCREMENT_EN
      i_upd_en      <= 1'b0;
      i_upd_val     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q           <= last_reg;
            idx           <= '0;
            busy          <= 1'b1;
            mem_addr      <= base_addr;
            rf_select_out <= '0;
            if (dir == DIR_STORE) begin
              state  <= STORE;
              mem_we <= 1'b1;
            end else begin
              state  <= LOAD;
            end
          end
        end

        STORE: begin
          if (idx == x_q) begin
            state         <= DONE;
            mem_we        <= 1'b0;
            done          <= 1'b1;
            rf_select_out <= '0;
            mem_addr      <= '0;
`ifdef CHIP8_I_INCREMENT_EN
            i_upd_en      <= 1'b1;
            i_upd_val     <= mem_addr + ADDR_W'(1);
`endif
          end else begin
            idx           <= idx + SEL_W'(1);
            rf_select_out <= idx + SEL_W'(1);
            mem_addr      <= mem_addr + ADDR_W'(1);
          end
        end

        // Read data for address k arrives in the following cycle, so the
        // register write trails the address by one (select = k-1).
        LOAD: begin
          rf_we        <= 1'b1;
          rf_select_in <= idx;
          if (idx == x_q) begin
            state <= LOAD_TAIL;
          end else begin
            idx      <= idx + SEL_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end

        LOAD_TAIL: begin
          state        <= DONE;
          rf_we        <= 1'b0;
          rf_select_in <= '0;
          done         <= 1'b1;
          mem_addr     <= '0;
`ifdef CHIP8_I_INCREMENT_EN
          i_upd_en     <= 1'b1;
          i_upd_val    <= mem_addr + ADDR_W'(1);
`endif
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
`ifdef CHIP8_I_INCREMENT_EN
          i_upd_en  <= 1'b0;
          i_upd_val <= '0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_mem_transfer.sv
// tb_reg_mem_transfer: directed self-checking bench for reg_mem_transfer.
// Models a 16x8 register file (async read) and a 4Kx8 synchronous RAM.
module tb_reg_mem_transfer;

  localparam int NC = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dir;
  logic [3:0]  last_reg;
  logic [11:0] base_addr;
  logic        busy, done, rf_we, mem_we, i_upd_en;
  logic [3:0]  rf_select_out, rf_select_in;
  logic [7:0]  rf_out_data, rf_in_data, mem_wdata, mem_rdata;
  logic [11:0] mem_addr, i_upd_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_mem_transfer dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .last_reg(last_reg),
    .base_addr(base_addr), .busy(busy), .done(done),
    .rf_select_out(rf_select_out), .rf_out_data(rf_out_data),
    .rf_we(rf_we), .rf_select_in(rf_select_in), .rf_in_data(rf_in_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .i_upd_en(i_upd_en), .i_upd_val(i_upd_val)
  );

  // models, with a backdoor write port for preloading
  logic [7:0]  regs [16];
  logic [7:0]  ram  [4096];
  logic        bd_rf_we = 1'b0, bd_ram_we = 1'b0;
  logic [3:0]  bd_rf_sel = '0;
  logic [11:0] bd_ram_a = '0;
  logic [7:0]  bd_d = '0;

  assign rf_out_data = regs[rf_select_out];

  always @(posedge clk) begin
    if (bd_rf_we) regs[bd_rf_sel] <= bd_d;
    else if (rf_we) regs[rf_select_in] <= rf_in_data;
  end

  always @(posedge clk) begin
    if (bd_ram_we) ram[bd_ram_a] <= bd_d;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // per-cycle capture of one operation (index 1 = first cycle after start)
  logic        lg_we   [NC];
  logic        lg_rfwe [NC];
  logic        lg_done [NC];
  logic        lg_busy [NC];
  logic        lg_iue  [NC];
  logic [11:0] lg_addr [NC];
  logic [11:0] lg_iuv  [NC];
  logic [7:0]  lg_wd   [NC];
  logic [7:0]  lg_rfd  [NC];
  logic [3:0]  lg_rfsel[NC];

  task automatic poke_reg(input logic [3:0] s, input logic [7:0] d);
    @(negedge clk); bd_rf_we = 1'b1; bd_rf_sel = s; bd_d = d;
    @(negedge clk); bd_rf_we = 1'b0;
  endtask

  task automatic poke_ram(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk); bd_ram_we = 1'b1; bd_ram_a = a; bd_d = d;
    @(negedge clk); bd_ram_we = 1'b0;
  endtask

  // rc: cycle at which a second (to be ignored) start is pulsed; 0 = none
  task automatic run_op(input logic d, input logic [3:0] x, input logic [11:0] b,
                        input int rc, input logic rd, input logic [3:0] rx,
                        input logic [11:0] rb);
    @(negedge clk); dir = d; last_reg = x; base_addr = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c < NC; c++) begin
      lg_we[c] = mem_we; lg_rfwe[c] = rf_we; lg_done[c] = done; lg_busy[c] = busy;
      lg_addr[c] = mem_addr; lg_wd[c] = mem_wdata; lg_rfd[c] = rf_in_data;
      lg_rfsel[c] = rf_select_in; lg_iue[c] = i_upd_en; lg_iuv[c] = i_upd_val;
      if (c == rc) begin
        start = 1'b1; dir = rd; last_reg = rx; base_addr = rb;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({busy, done, rf_we, mem_we, i_upd_en} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes got %b want 00000", {busy, done, rf_we, mem_we, i_upd_en});
    end
    n_cmp++;
    if ({mem_addr, rf_select_out, rf_select_in, mem_wdata, rf_in_data, i_upd_val} !== '0) begin
      n_err++; $display("FAIL reset_buses addr=%h rso=%h rsi=%h wd=%h rd=%h iv=%h",
                        mem_addr, rf_select_out, rf_select_in, mem_wdata, rf_in_data, i_upd_val);
    end
  endtask

  task automatic test_store;
    logic [7:0] vals [4];
    vals[0] = 8'd11; vals[1] = 8'd22; vals[2] = 8'd33; vals[3] = 8'd44;
    for (int i = 0; i < 4; i++) poke_reg(4'(i), vals[i]);
    run_op(1'b0, 4'd3, 12'h300, 0, 1'b0, 4'd0, 12'h0);
    for (int c = 1; c <= 6; c++) begin
      n_cmp++;
      if (lg_we[c] !== (c <= 4)) begin
        n_err++; $display("FAIL store_we c=%0d got %b want %b", c, lg_we[c], c <= 4);
      end
      if (c <= 4) begin
        n_cmp++;
        if (lg_addr[c] !== 12'h300 + 12'(c - 1) || lg_wd[c] !== vals[c-1]) begin
          n_err++; $display("FAIL store_wr c=%0d got %h/%0d want %h/%0d", c, lg_addr[c], lg_wd[c],
                            12'h300 + 12'(c - 1), vals[c-1]);
        end
      end
      n_cmp++;
      if (lg_done[c] !== (c == 5) || lg_busy[c] !== (c <= 5) || lg_rfwe[c] !== 1'b0) begin
        n_err++; $display("FAIL store_ctl c=%0d got done=%b busy=%b rfwe=%b", c, lg_done[c],
                          lg_busy[c], lg_rfwe[c]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ram[12'h300 + 12'(i)] !== vals[i]) begin
        n_err++; $display("FAIL store_ram i=%0d got %0d want %0d", i, ram[12'h300 + 12'(i)], vals[i]);
      end
    end
`ifdef CHIP8_I_INCREMENT_EN
    n_cmp++;
    if (lg_iue[5] !== 1'b1 || lg_iuv[5] !== 12'h304 || lg_iue[4] !== 1'b0 || lg_iue[6] !== 1'b0) begin
      n_err++; $display("FAIL store_iupd got en4/5/6=%b%b%b val=%h want 010 304",
                        lg_iue[4], lg_iue[5], lg_iue[6], lg_iuv[5]);
    end
`else
    n_cmp++;
    if (lg_iue[5] !== 1'b0 || lg_iuv[5] !== 12'h000) begin
      n_err++; $display("FAIL store_iupd got en=%b val=%h want 0 000", lg_iue[5], lg_iuv[5]);
    end
`endif
  endtask

  task automatic test_wrap;
    logic [11:0] exp_a [4];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    run_op(1'b0, 4'd3, 12'hFFE, 0, 1'b0, 4'd0, 12'h0);
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if (lg_we[c] !== 1'b1 || lg_addr[c] !== exp_a[c-1]) begin
        n_err++; $display("FAIL wrap_addr c=%0d got we=%b %h want 1 %h", c, lg_we[c], lg_addr[c], exp_a[c-1]);
      end
    end
    n_cmp++;
    if (ram[12'h000] !== 8'd33 || ram[12'h001] !== 8'd44) begin
      n_err++; $display("FAIL wrap_ram got %0d %0d want 33 44", ram[12'h000], ram[12'h001]);
    end
`ifdef CHIP8_I_INCREMENT_EN
    n_cmp++;
    if (lg_iuv[5] !== 12'h002) begin
      n_err++; $display("FAIL wrap_iupd got %h want 002", lg_iuv[5]);
    end
`endif
  endtask

  task automatic test_back_to_back_start;
    // V0=11, V1=22 from the store test; the second start must be ignored
    run_op(1'b0, 4'd1, 12'h100, 2, 1'b1, 4'd5, 12'h400);
    for (int c = 1; c <= 8; c++) begin
      n_cmp++;
      if (lg_we[c] !== (c <= 2) || lg_rfwe[c] !== 1'b0 || lg_done[c] !== (c == 3) ||
          lg_busy[c] !== (c <= 3)) begin
        n_err++; $display("FAIL restart_ctl c=%0d got we=%b rfwe=%b done=%b busy=%b", c, lg_we[c],
                          lg_rfwe[c], lg_done[c], lg_busy[c]);
      end
    end
    n_cmp++;
    if (lg_addr[1] !== 12'h100 || lg_addr[2] !== 12'h101) begin
      n_err++; $display("FAIL restart_addr got %h %h want 100 101", lg_addr[1], lg_addr[2]);
    end
    n_cmp++;
    if (ram[12'h100] !== 8'd11 || ram[12'h101] !== 8'd22) begin
      n_err++; $display("FAIL restart_ram got %0d %0d want 11 22", ram[12'h100], ram[12'h101]);
    end
  endtask

  task automatic test_load;
    int nwe;
    for (int i = 0; i < 16; i++) poke_ram(12'h200 + 12'(i), 8'hA0 + 8'(i));
    run_op(1'b1, 4'hF, 12'h200, 0, 1'b0, 4'd0, 12'h0);
    nwe = 0;
    for (int c = 1; c < NC; c++) if (lg_rfwe[c]) nwe++;
    n_cmp++;
    if (nwe !== 16) begin
      n_err++; $display("FAIL load_count got %0d want 16", nwe);
    end
    n_cmp++;
    if (lg_rfwe[1] !== 1'b0 || lg_addr[1] !== 12'h200) begin
      n_err++; $display("FAIL load_first got rfwe=%b addr=%h want 0 200", lg_rfwe[1], lg_addr[1]);
    end
    for (int c = 2; c <= 17; c++) begin
      n_cmp++;
      if (lg_rfwe[c] !== 1'b1 || lg_rfsel[c] !== 4'(c - 2) || lg_rfd[c] !== 8'hA0 + 8'(c - 2) ||
          lg_we[c] !== 1'b0) begin
        n_err++; $display("FAIL load_wr c=%0d got we=%b sel=%h d=%h mwe=%b want 1 %h %h 0", c, lg_rfwe[c],
                          lg_rfsel[c], lg_rfd[c], lg_we[c], 4'(c - 2), 8'hA0 + 8'(c - 2));
      end
    end
    n_cmp++;
    if (lg_done[18] !== 1'b1 || lg_rfwe[18] !== 1'b0 || lg_busy[19] !== 1'b0 || lg_done[17] !== 1'b0) begin
      n_err++; $display("FAIL load_done got d17=%b d18=%b rfwe18=%b busy19=%b", lg_done[17], lg_done[18],
                        lg_rfwe[18], lg_busy[19]);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (regs[i] !== 8'hA0 + 8'(i)) begin
        n_err++; $display("FAIL load_reg V%0h got %h want %h", i, regs[i], 8'hA0 + 8'(i));
      end
    end
`ifdef CHIP8_I_INCREMENT_EN
    n_cmp++;
    if (lg_iue[18] !== 1'b1 || lg_iuv[18] !== 12'h210) begin
      n_err++; $display("FAIL load_iupd got %b %h want 1 210", lg_iue[18], lg_iuv[18]);
    end
`endif
  endtask

  task automatic test_load_x0;
    int nwe, nbusy;
    poke_ram(12'h050, 8'h5A);
    run_op(1'b1, 4'd0, 12'h050, 0, 1'b0, 4'd0, 12'h0);
    nwe = 0; nbusy = 0;
    for (int c = 1; c < NC; c++) begin
      if (lg_rfwe[c]) nwe++;
      if (lg_busy[c]) nbusy++;
    end
    n_cmp++;
    if (nwe !== 1 || nbusy !== 3) begin
      n_err++; $display("FAIL x0_counts got rfwe=%0d busy=%0d want 1 3", nwe, nbusy);
    end
    n_cmp++;
    if (lg_rfwe[2] !== 1'b1 || lg_rfsel[2] !== 4'd0 || lg_rfd[2] !== 8'h5A || lg_done[3] !== 1'b1) begin
      n_err++; $display("FAIL x0_write got we=%b sel=%h d=%h done3=%b", lg_rfwe[2], lg_rfsel[2],
                        lg_rfd[2], lg_done[3]);
    end
    n_cmp++;
    if (regs[0] !== 8'h5A || regs[1] !== 8'hA1) begin
      n_err++; $display("FAIL x0_regs got %h %h want 5a a1", regs[0], regs[1]);
    end
  endtask

  task automatic test_mid_reset;
    int bad;
    // V0=5A, V1=A1, V2=A2 at this point
    poke_ram(12'h602, 8'hEE);
    @(negedge clk); dir = 1'b0; last_reg = 4'd3; base_addr = 12'h600; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 12'h602) begin
      n_err++; $display("FAIL midrst_pre got we=%b addr=%h want 1 602", mem_we, mem_addr);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, mem_we, rf_we} !== 4'b0 || mem_addr !== 12'h0 || mem_wdata !== 8'h0 ||
        rf_select_out !== 4'h0) begin
      n_err++; $display("FAIL midrst_now got strobes=%b addr=%h wd=%h rso=%h", {busy, done, mem_we, rf_we},
                        mem_addr, mem_wdata, rf_select_out);
    end
    @(negedge clk); reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || mem_we || busy) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL midrst_after got %0d active cycles want 0", bad);
    end
    n_cmp++;
    if (ram[12'h600] !== 8'h5A || ram[12'h601] !== 8'hA1 || ram[12'h602] !== 8'hEE) begin
      n_err++; $display("FAIL midrst_ram got %h %h %h want 5a a1 ee", ram[12'h600], ram[12'h601],
                        ram[12'h602]);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; last_reg = '0; base_addr = '0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_store;
    test_wrap;
    test_back_to_back_start;
    test_load;
    test_load_x0;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
